// File: rtl/rr_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter8_pkg
// Purpose : shared definitions for the eight-requester round-robin arbiter:
//           requester count, grant index width and the arbiter state encoding.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // IDLE: nobody owns the resource; GRANT: gnt_idx names the current owner.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : rr_arbiter8_pkg

// File: rtl/rr_arbiter8_decoder.sv
// -----------------------------------------------------------------------------
// decoder3_8
// Purpose : 3-to-8 one-hot decoder. {in1,in2,in3} forms a binary index with
//           in1 as the most significant bit; out has exactly that bit set.
// Ports   : in1, in2, in3 - index bits (in1 = MSB)
//           out [7:0]     - one-hot decode of the index
// -----------------------------------------------------------------------------
module decoder3_8 (
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [7:0] out
);

    logic [2:0] w_sel;

    assign w_sel = {in1, in2, in3};

    // Binary index to one-hot conversion.
    always_comb begin
        out = 8'h00;
        case (w_sel)
            3'd0:    out = 8'h01;
            3'd1:    out = 8'h02;
            3'd2:    out = 8'h04;
            3'd3:    out = 8'h08;
            3'd4:    out = 8'h10;
            3'd5:    out = 8'h20;
            3'd6:    out = 8'h40;
            3'd7:    out = 8'h80;
            default: out = 8'h00;
        endcase
    end

endmodule : decoder3_8

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
// Purpose : eight-requester round-robin arbiter with a hold-time limit. The
//           owner index is registered and decoded to a one-hot grant vector.
//           Priority rotates: the search for the next owner starts just after
//           the most recent winner, so every requester is eventually served.
// Params  : HOLD_MAX - max consecutive grant cycles per owner while others
//                      are waiting (2..256)
// Ports   : sys_clk      - clock, all state changes on the rising edge
//           sys_rst      - synchronous active-high reset
//           req   [7:0]  - level requests, one bit per master
//           gnt_idx [2:0]- registered index of the current owner
//           gnt_vld      - registered, high while gnt_idx names an owner
//           gnt   [7:0]  - one-hot grant, all zero when idle
//           rearb        - one-cycle pulse when a new owner takes over
// -----------------------------------------------------------------------------
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic [N_REQ-1:0] gnt,
    output logic             rearb
);

    localparam int                HC_W      = $clog2(HOLD_MAX);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_MAX - 1);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic              r_gnt_vld;
    logic              r_rearb;
    logic [HC_W-1:0]   r_hold_cnt;
    logic [IDX_W-1:0]  r_last_ptr;

    logic [N_REQ-1:0]  w_cur_mask;
    logic [N_REQ-1:0]  w_others;
    logic              w_cur_req;
    logic [IDX_W:0]    w_first;   // {found, index} over all requests
    logic [IDX_W:0]    w_next;    // {found, index} over requests other than owner
    logic [N_REQ-1:0]  w_dec;

    // Rotating find-first: rotate so that ptr+1 lands at bit 0, pick the lowest
    // set bit, then add the rotation back (3-bit add gives the mod-8 wrap).
    function automatic logic [IDX_W:0] find_next(
        input logic [N_REQ-1:0] reqv,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0]   start;
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   idx;
        start = ptr + 3'd1;
        dbl   = {reqv, reqv} >> start;
        rot   = dbl[N_REQ-1:0];
        idx   = 3'd0;
        // Descending scan so the lowest set rotated bit is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = start + IDX_W'(k);
            end else begin
                idx = idx;
            end
        end
        return {|rot, idx};
    endfunction

    // Requests competing against the current owner.
    always_comb begin
        w_cur_mask = 8'd1 << r_gnt_idx;
        w_others   = req & ~w_cur_mask;
        w_cur_req  = req[r_gnt_idx];
        w_first    = find_next(req, r_last_ptr);
        w_next     = find_next(w_others, r_last_ptr);
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= 3'd0;
            r_gnt_vld  <= 1'b0;
            r_rearb    <= 1'b0;
            r_hold_cnt <= {HC_W{1'b0}};
            r_last_ptr <= 3'd7;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_first[IDX_W]) begin
                        r_state    <= ST_GRANT;
                        r_gnt_idx  <= w_first[IDX_W-1:0];
                        r_last_ptr <= w_first[IDX_W-1:0];
                        r_gnt_vld  <= 1'b1;
                        r_rearb    <= 1'b1;
                        r_hold_cnt <= {HC_W{1'b0}};
                    end else begin
                        r_rearb    <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Release is checked first so it wins over a hold expiry
                    // landing on the same cycle.
                    if (!w_cur_req) begin
                        if (w_next[IDX_W]) begin
                            r_gnt_idx  <= w_next[IDX_W-1:0];
                            r_last_ptr <= w_next[IDX_W-1:0];
                            r_rearb    <= 1'b1;
                            r_hold_cnt <= {HC_W{1'b0}};
                        end else begin
                            r_state    <= ST_IDLE;
                            r_gnt_vld  <= 1'b0;
                            r_rearb    <= 1'b0;
                            r_hold_cnt <= {HC_W{1'b0}};
                        end
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        if (w_next[IDX_W]) begin
                            r_gnt_idx  <= w_next[IDX_W-1:0];
                            r_last_ptr <= w_next[IDX_W-1:0];
                            r_rearb    <= 1'b1;
                            r_hold_cnt <= {HC_W{1'b0}};
                        end else begin
                            // Nobody waiting: keep the owner, restart the window.
                            r_rearb    <= 1'b0;
                            r_hold_cnt <= {HC_W{1'b0}};
                        end
                    end else begin
                        r_rearb    <= 1'b0;
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_gnt_idx  <= 3'd0;
                    r_gnt_vld  <= 1'b0;
                    r_rearb    <= 1'b0;
                    r_hold_cnt <= {HC_W{1'b0}};
                    r_last_ptr <= 3'd7;
                end
            endcase
        end
    end

    decoder3_8 decoder3_8_inst (
        .in1 (r_gnt_idx[2]),
        .in2 (r_gnt_idx[1]),
        .in3 (r_gnt_idx[0]),
        .out (w_dec)
    );

    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign rearb   = r_rearb;
    assign gnt     = w_dec & {N_REQ{r_gnt_vld}};

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] req;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt;
    logic       rearb;

    int unsigned cyc;
    int          checks;
    int          errors;

    typedef struct {
        int unsigned cyc;
        logic        vld;
        logic [2:0]  idx;
        logic [7:0]  gnt;
        logic        rearb;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt),
        .rearb   (rearb)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [7:0] q, input logic v,
                        input logic [2:0] i, input logic [7:0] g,
                        input logic rb, input string nm);
        exp_t e;
        @(negedge sys_clk);
        sys_rst = r;
        req     = q;
        e.cyc   = cyc + 1;
        e.vld   = v;
        e.idx   = i;
        e.gnt   = g;
        e.rearb = rb;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare outputs against queued expectations for this cycle.
    always @(negedge sys_clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                         e.name, e.cyc, cyc);
            end else if ({gnt_vld, gnt_idx, gnt, rearb} !== {e.vld, e.idx, e.gnt, e.rearb}) begin
                errors = errors + 1;
                $display("FAIL %s cyc %0d: got vld=%b idx=%0d gnt=%h rearb=%b, want vld=%b idx=%0d gnt=%h rearb=%b",
                         e.name, cyc, gnt_vld, gnt_idx, gnt, rearb,
                         e.vld, e.idx, e.gnt, e.rearb);
            end
        end
    end

    initial begin
        logic [2:0] rot_own [4];
        logic [7:0] rot_gnt [4];
        rot_own = '{3'd0, 3'd4, 3'd7, 3'd0};
        rot_gnt = '{8'h01, 8'h10, 8'h80, 8'h01};
        checks  = 0;
        errors  = 0;
        sys_rst = 1'b1;
        req     = 8'hFF;

        // 1: reset with all requests high, then first grant to index 0.
        step(1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, "t1_reset_a");
        step(1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, "t1_reset_b");
        step(1'b0, 8'hFF, 1'b1, 3'd0, 8'h01, 1'b1, "t1_first_grant");
        step(1'b0, 8'hFF, 1'b1, 3'd0, 8'h01, 1'b0, "t1_hold");

        // 2: two requesters alternate every HOLD_MAX=4 cycles.
        step(1'b1, 8'h24, 1'b0, 3'd0, 8'h00, 1'b0, "t2_reset");
        for (int k = 0; k < 16; k++) begin
            if (((k / 4) % 2) == 0)
                step(1'b0, 8'h24, 1'b1, 3'd2, 8'h04, (k % 4) == 0, "t2_alt_own2");
            else
                step(1'b0, 8'h24, 1'b1, 3'd5, 8'h20, (k % 4) == 0, "t2_alt_own5");
        end

        // Three requesters rotate 0 -> 4 -> 7 -> 0 (wrap).
        step(1'b1, 8'h91, 1'b0, 3'd0, 8'h00, 1'b0, "rot_reset");
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 8'h91, 1'b1, rot_own[k / 4], rot_gnt[k / 4], (k % 4) == 0, "rot_3req");
        end

        // 3: lone requester 7 keeps the grant across hold-window wraps.
        step(1'b1, 8'h80, 1'b0, 3'd0, 8'h00, 1'b0, "t3_reset");
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 8'h80, 1'b1, 3'd7, 8'h80, k == 0, "t3_single_owner");
        end

        // 4: owner 7 releases, wrap to 0; owner 0 releases, grant to 1.
        step(1'b0, 8'h03, 1'b1, 3'd0, 8'h01, 1'b1, "t4_wrap_to_0");
        step(1'b0, 8'h02, 1'b1, 3'd1, 8'h02, 1'b1, "t4_release_to_1");
        step(1'b0, 8'h02, 1'b1, 3'd1, 8'h02, 1'b0, "t4_hold_1");

        // 5: owner 3 releases to idle, then re-requests.
        step(1'b1, 8'h08, 1'b0, 3'd0, 8'h00, 1'b0, "t5_reset");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b1, "t5_grant3");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b0, "t5_hold3");
        step(1'b0, 8'h00, 1'b0, 3'd3, 8'h00, 1'b0, "t5_idle");
        step(1'b0, 8'h00, 1'b0, 3'd3, 8'h00, 1'b0, "t5_idle_stay");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b1, "t5_regrant3");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b0, "t5_cnt1");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b0, "t5_cnt2");
        step(1'b0, 8'h08, 1'b1, 3'd3, 8'h08, 1'b0, "t5_cnt3");
        // Release coincides with hold expiry: hand over to waiting requester 4.
        step(1'b0, 8'h10, 1'b1, 3'd4, 8'h10, 1'b1, "t5_release_at_expiry");

        // 6: reset mid-grant, search restarts at 0.
        step(1'b1, 8'h60, 1'b0, 3'd0, 8'h00, 1'b0, "t6_reset");
        step(1'b0, 8'h60, 1'b1, 3'd5, 8'h20, 1'b1, "t6_grant5");
        step(1'b0, 8'h60, 1'b1, 3'd5, 8'h20, 1'b0, "t6_hold5");
        step(1'b1, 8'h60, 1'b0, 3'd0, 8'h00, 1'b0, "t6_mid_reset");
        step(1'b0, 8'h60, 1'b1, 3'd5, 8'h20, 1'b1, "t6_after_reset");

        @(negedge sys_clk);
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter8
